instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Instruction producer for the single-cycle core's control decoder. Accepts
//  mnemonic-level requests (ALU, extended MUL, LDR/STR, B) over valid/ready.
//  Packs each into the 32-bit word format the decoder expects, then writes it
//  sequentially into instruction memory. Serves as the program loader / self-test
//  source ahead of the core.
// PARAMETERS
//  ADDR_W     6  word-address width; buffer depth = 2**ADDR_W words
//  BASE_ADDR  0  first instruction-memory word address written after reset/clear
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  clear        in   1       sync restart: write pointer back to BASE_ADDR, err cleared
//  req_valid    in   1       request present
//  req_ready    out  1       encoder can accept a request
//  req_kind     in   4       0 ADD 1 SUB 2 AND 3 ORR 4 ADD32 5 ADD16 6 MUL 7 UMULL
//                            8 SMULL 9 MULL32 10 MULL16 11 LDR 12 STR 13 B 14-15 illegal
//  req_cond     in   4       condition field [31:28]
//  req_s        in   1       S bit (ALU/MUL kinds only; forced 0 otherwise)
//  req_use_imm  in   1       ALU kinds: 1 = immediate Src2, 0 = register Rm
//  req_rd,req_rn,req_rm,req_ra  in  4 each  register fields
//  req_imm      in   24      immediate / branch word offset
//  im_we        out  1       instruction-memory write strobe
//  im_addr      out  ADDR_W  write word address
//  im_wd        out  32      encoded instruction word
//  full         out  1       2**ADDR_W words written since reset/clear
//  err_illegal  out  1       one-cycle pulse: request rejected, nothing written
// BEHAVIOUR
//  Reset:
//   - All outputs 0; state IDLE; pointer = BASE_ADDR; count = 0.
//  FSM IDLE -> ENC -> WRITE -> IDLE:
//   - req_ready = (state==IDLE) & ~full & ~clear.
//   - Request accepted on valid&ready; fields latched into registers.
//   - ENC: build word into register; check legality.
//     - Illegal -> err_illegal=1 for that cycle, then IDLE with no write.
//     - Legal -> WRITE.
//   - WRITE: im_we=1 for exactly one cycle; im_addr = pointer; im_wd = word;
//     then pointer+1, count+1, back to IDLE.
//   - Accept at edge N -> im_we high in cycle N+2. Throughput: 1 request per 3 cycles.
//  Encoding (bits [31:28] = cond):
//   - ALU: [27:26]=00, [25]=use_imm, [24:21]=cmd, [20]=S, [19:16]=Rn, [15:12]=Rd.
//     - cmd: ADD 0100, SUB 0010, AND 0000, ORR 1100, ADD32 1010, ADD16 1011.
//     - Src2: imm -> {4'h0, imm[7:0]}; reg -> {8'h00, Rm}.
//   - MUL family: [27:24]=0000, [23:21] = MUL 000, UMULL 100, SMULL 110,
//     MULL32 101, MULL16 111; [20]=S; [19:16]=Rd; [15:12]=Ra (0 for MUL);
//     [11:8]=Rm; [7:4]=1001; [3:0]=Rn.
//   - LDR/STR: [27:20] = 0101_100L (L=1 for LDR); [19:16]=Rn; [15:12]=Rd;
//     [11:0]=imm[11:0].
//   - B: [27:24]=1010, [23:0]=imm.
//  Illegal:
//   - kind 14/15.
//   - ALU imm with imm[23:8] != 0.
//   - LDR/STR with imm[23:12] != 0.
//   - MUL family with Rd==15 or Ra==15.
//  Full / wrap:
//   - full sets when count reaches 2**ADDR_W.
//   - Pointer wraps modulo 2**ADDR_W but no further accepts occur until clear.
//  Clear:
//   - Takes priority over accept in the same cycle; the request is not taken.
//   - During ENC/WRITE, aborts to IDLE with no write and clears full.
//  Reset mid-operation:
//   - Aborts immediately; im_we is 0 in the cycle after the reset edge.
// TESTING
//  1. ADD r1,r2,#5 cond=E S=0 imm -> im_we 2 cycles after accept; addr 0; wd=E2821005.
//  2. SUBS r3,r4,r5 (reg) -> E0543005; then MUL rd=0 rn=1 rm=2 -> E0000291 at addr 1.
//  3. UMULL rd=1 ra=2 rm=3 rn=4 -> E0812394.
//     LDR r1,[r2,#8] -> E5921008. STR same fields -> E5821008.
//     B imm=000010 -> EA000010.
//  4. Illegal: kind 14; ALU imm 0x100; MUL rd=15 -> err_illegal pulses,
//     no im_we, pointer unchanged.
//  5. ADDR_W=2: four writes -> full=1, req_ready=0, fifth valid stalls;
//     clear -> full=0, next write at BASE_ADDR.
//  6. Reset or clear asserted in WRITE-bound ENC cycle -> no write.
//     clear concurrent with valid -> request not accepted.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: packs mnemonic requests into 32-bit instruction words
// and writes them sequentially into instruction memory (IDLE -> ENC -> WRITE).
module instr_encoder #(
   parameter int ADDR_W    = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_kind,
   input  logic [3:0]        req_cond,
   input  logic              req_s,
   input  logic              req_use_imm,
   input  logic [3:0]        req_rd,
   input  logic [3:0]        req_rn,
   input  logic [3:0]        req_rm,
   input  logic [3:0]        req_ra,
   input  logic [23:0]       req_imm,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wd,
   output logic              full,
   output logic              err_illegal
);

   localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(1) << ADDR_W;

   typedef enum logic [1:0] {IDLE, ENC, WRITE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        kind_p0, cond_p0, rd_p0, rn_p0, rm_p0, ra_p0;
   logic              s_p0, use_imm_p0;
   logic [23:0]       imm_p0;
   logic [31:0]       word_p0, word_p1;
   logic              illegal_p0;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   count;
   logic              accept;

   function automatic logic [31:0] encode(input logic [3:0] kind, cond, rd, rn, rm, ra,
                                          input logic s, use_imm,
                                          input logic [23:0] imm);
      logic [31:0] w;
      logic [3:0]  cmd;
      logic [2:0]  op;
      logic [11:0] src2;
      w    = {cond, 28'h0};
      cmd  = 4'b0000;
      op   = 3'b000;
      src2 = use_imm ? {4'h0, imm[7:0]} : {8'h00, rm};
      case (kind)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
            case (kind)
               4'd0:    cmd = 4'b0100;
               4'd1:    cmd = 4'b0010;
               4'd2:    cmd = 4'b0000;
               4'd3:    cmd = 4'b1100;
               4'd4:    cmd = 4'b1010;
               default: cmd = 4'b1011;
            endcase
            w = {cond, 2'b00, use_imm, cmd, s, rn, rd, src2};
         end
         4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
            case (kind)
               4'd6:    op = 3'b000;
               4'd7:    op = 3'b100;
               4'd8:    op = 3'b110;
               4'd9:    op = 3'b101;
               default: op = 3'b111;
            endcase
            // Plain MUL has no accumulate register, so its Ra field is zero.
            w = {cond, 4'b0000, op, s, rd, (kind == 4'd6) ? 4'h0 : ra, rm, 4'b1001, rn};
         end
         4'd11, 4'd12: w = {cond, 7'b0101_100, kind == 4'd11, rn, rd, imm[11:0]};
         4'd13:        w = {cond, 4'b1010, imm};
         default:      w = {cond, 28'h0};
      endcase
      return w;
   endfunction

   function automatic logic is_illegal(input logic [3:0] kind, rd, ra,
                                       input logic use_imm,
                                       input logic [23:0] imm);
      logic alu, mul, mem;
      alu = (kind <= 4'd5);
      mul = (kind >= 4'd6) && (kind <= 4'd10);
      mem = (kind == 4'd11) || (kind == 4'd12);
      return (kind >= 4'd14)
          || (alu && use_imm && (|imm[23:8]))
          || (mem && (|imm[23:12]))
          || (mul && ((rd == 4'hF) || (ra == 4'hF)));
   endfunction

   assign full        = (count == DEPTH);
   assign req_ready   = (state == IDLE) && !full && !clear && !reset;
   assign accept      = req_valid && req_ready;
   assign word_p0     = encode(kind_p0, cond_p0, rd_p0, rn_p0, rm_p0, ra_p0,
                               s_p0, use_imm_p0, imm_p0);
   assign illegal_p0  = is_illegal(kind_p0, rd_p0, ra_p0, use_imm_p0, imm_p0);
   assign im_we       = (state == WRITE) && !clear && !reset;
   assign im_addr     = im_we ? ptr : '0;
   assign im_wd       = im_we ? word_p1 : 32'h0;
   assign err_illegal = (state == ENC) && illegal_p0 && !clear && !reset;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ENC;
         ENC:     state_nxt = (clear || illegal_p0) ? IDLE : WRITE;
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= BASE_PTR;
         count <= '0;
      end else begin
         state <= state_nxt;
         if (clear) begin
            ptr   <= BASE_PTR;
            count <= '0;
         end else if (state == WRITE) begin
            ptr   <= ptr + 1'b1;
            count <= count + 1'b1;
         end
      end
   end

   // Stage p0: request fields held for encoding
   always_ff @(posedge clk) begin
      if (accept) begin
         kind_p0    <= req_kind;
         cond_p0    <= req_cond;
         s_p0       <= req_s;
         use_imm_p0 <= req_use_imm;
         rd_p0      <= req_rd;
         rn_p0      <= req_rn;
         rm_p0      <= req_rm;
         ra_p0      <= req_ra;
         imm_p0     <= req_imm;
      end
   end

   // Stage p1: encoded word held for the write cycle
   always_ff @(posedge clk) begin
      if (state == ENC) word_p1 <= word_p0;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_instr_encoder;

   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int BASE  = 0;

   logic          clk = 1'b0;
   logic          reset, clear, req_valid, req_ready;
   logic [3:0]    req_kind, req_cond, req_rd, req_rn, req_rm, req_ra;
   logic          req_s, req_use_imm;
   logic [23:0]   req_imm;
   logic          im_we, full, err_illegal;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wd;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .req_cond(req_cond), .req_s(req_s),
      .req_use_imm(req_use_imm), .req_rd(req_rd), .req_rn(req_rn),
      .req_rm(req_rm), .req_ra(req_ra), .req_imm(req_imm),
      .im_we(im_we), .im_addr(im_addr), .im_wd(im_wd),
      .full(full), .err_illegal(err_illegal)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned alu_cmd [6] = '{4, 2, 0, 12, 10, 11};
   int unsigned mul_op  [5] = '{0, 4, 6, 5, 7};

   function automatic int unsigned m_encode(input int unsigned kind, cond, s, ui,
                                            rd, rn, rm, ra, imm);
      int unsigned w;
      w = cond << 28;
      if (kind <= 5)
         w += (ui << 25) + (alu_cmd[kind] << 21) + (s << 20) + (rn << 16) + (rd << 12)
              + (ui != 0 ? imm % 256 : rm);
      else if (kind <= 10)
         w += (mul_op[kind-6] << 21) + (s << 20) + (rd << 16)
              + ((kind == 6 ? 0 : ra) << 12) + (rm << 8) + (9 << 4) + rn;
      else if (kind <= 12)
         w += ((kind == 11 ? 32'h59 : 32'h58) << 20) + (rn << 16) + (rd << 12) + imm % 4096;
      else if (kind == 13)
         w += (32'hA << 24) + imm;
      return w;
   endfunction

   function automatic bit m_illegal(input int unsigned kind, ui, rd, ra, imm);
      if (kind >= 14) return 1;
      if (kind <= 5 && ui != 0 && imm >= 256) return 1;
      if ((kind == 11 || kind == 12) && imm >= 4096) return 1;
      if (kind >= 6 && kind <= 10 && (rd == 15 || ra == 15)) return 1;
      return 0;
   endfunction

   bit          started = 0;
   bit          m_pend  = 0;
   int          m_age   = 0;
   int unsigned m_ptr   = BASE;
   int unsigned m_count = 0;
   int unsigned m_word  = 0;
   bit          m_ill   = 0;

   always @(posedge clk) begin
      if (reset || clear) begin
         m_pend  = 0;
         m_ptr   = BASE;
         m_count = 0;
      end else if (m_pend) begin
         if (m_age == 1) begin
            if (m_ill) m_pend = 0;
            else m_age = 2;
         end else begin
            m_ptr   = (m_ptr + 1) % DEPTH;
            m_count = m_count + 1;
            m_pend  = 0;
         end
      end else if (req_valid && m_count < DEPTH) begin
         m_word = m_encode(req_kind, req_cond, req_s, req_use_imm, req_rd, req_rn,
                           req_rm, req_ra, req_imm);
         m_ill  = m_illegal(req_kind, req_use_imm, req_rd, req_ra, req_imm);
         m_pend = 1;
         m_age  = 1;
      end
      started = 1;
   end

   bit          exp_ready, exp_err, exp_we;
   int          wr_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] last_wd = 0;
   logic [31:0] last_addr = 0;

   always @(negedge clk) begin
      if (started) begin
         exp_ready = !reset && !clear && !m_pend && (m_count < DEPTH);
         exp_err   = m_pend && m_age == 1 && m_ill && !clear && !reset;
         exp_we    = m_pend && m_age == 2 && !clear && !reset;
         check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
         check("err_illegal", {31'b0, err_illegal}, {31'b0, exp_err});
         check("im_we", {31'b0, im_we}, {31'b0, exp_we});
         check("full", {31'b0, full}, {31'b0, m_count == DEPTH});
         if (exp_we) begin
            check("im_addr", 32'(im_addr), m_ptr);
            check("im_wd", im_wd, m_word);
         end
         if (im_we === 1'b1) begin
            wr_cnt++;
            last_wd   = im_wd;
            last_addr = 32'(im_addr);
         end
         if (err_illegal === 1'b1) err_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_fields(input int unsigned kind, cond, s, ui, rd, rn, rm, ra, imm);
      req_kind    = 4'(kind);
      req_cond    = 4'(cond);
      req_s       = 1'(s);
      req_use_imm = 1'(ui);
      req_rd      = 4'(rd);
      req_rn      = 4'(rn);
      req_rm      = 4'(rm);
      req_ra      = 4'(ra);
      req_imm     = 24'(imm);
   endtask

   task automatic req(input int unsigned kind, cond, s, ui, rd, rn, rm, ra, imm,
                      output bit acc);
      set_fields(kind, cond, s, ui, rd, rn, rm, ra, imm);
      req_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 8 && !acc; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #2;
      end
      req_valid = 1'b0;
   endtask

   task automatic send_chk(input string name, input int unsigned kind, cond, s, ui, rd, rn,
                           rm, ra, imm, input logic [31:0] exp_wd, input int exp_addr);
      bit acc;
      req(kind, cond, s, ui, rd, rn, rm, ra, imm, acc);
      check({name, " accept"}, {31'b0, acc}, 32'd1);
      idle(3);
      check({name, " word"}, last_wd, exp_wd);
      check({name, " addr"}, last_addr, 32'(exp_addr));
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int w0, e0;
      int unsigned pick, imm;
      reset = 1'b1;
      clear = 1'b0;
      req_valid = 1'b0;
      set_fields(0, 0, 0, 0, 0, 0, 0, 0, 0);

      check("model ADD", m_encode(0, 14, 0, 1, 1, 2, 0, 0, 5), 32'hE2821005);
      check("model SUBS", m_encode(1, 14, 1, 0, 3, 4, 5, 0, 0), 32'hE0543005);
      check("model MUL", m_encode(6, 14, 0, 0, 0, 1, 2, 9, 0), 32'hE0000291);
      check("model UMULL", m_encode(7, 14, 0, 0, 1, 4, 3, 2, 0), 32'hE0812394);
      check("model LDR", m_encode(11, 14, 0, 0, 1, 2, 0, 0, 8), 32'hE5921008);
      check("model B", m_encode(13, 14, 0, 0, 0, 0, 0, 0, 16), 32'hEA000010);

      idle(3);
      @(negedge clk);
      check("reset im_we", {31'b0, im_we}, 32'd0);
      check("reset im_wd", im_wd, 32'd0);
      check("reset full", {31'b0, full}, 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      check("ready after reset", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #2;

      // ADD r1,r2,#5 with explicit latency
      req(0, 14, 0, 1, 1, 2, 0, 0, 5, acc);
      check("add accept", {31'b0, acc}, 32'd1);
      @(negedge clk);
      check("add enc cycle we", {31'b0, im_we}, 32'd0);
      @(negedge clk);
      check("add write cycle we", {31'b0, im_we}, 32'd1);
      check("add word", im_wd, 32'hE2821005);
      check("add addr", 32'(im_addr), 32'd0);
      @(posedge clk);
      #2;
      idle(1);

      pulse_clear();
      send_chk("subs", 1, 14, 1, 0, 3, 4, 5, 0, 0, 32'hE0543005, 0);
      send_chk("mul", 6, 14, 0, 0, 0, 1, 2, 0, 0, 32'hE0000291, 1);

      pulse_clear();
      send_chk("umull", 7, 14, 0, 0, 1, 4, 3, 2, 0, 32'hE0812394, 0);
      send_chk("ldr", 11, 14, 0, 0, 1, 2, 0, 0, 8, 32'hE5921008, 1);
      send_chk("str", 12, 14, 0, 0, 1, 2, 0, 0, 8, 32'hE5821008, 2);
      send_chk("b", 13, 14, 0, 0, 0, 0, 0, 0, 16, 32'hEA000010, 3);
      @(negedge clk);
      check("full set", {31'b0, full}, 32'd1);
      check("ready when full", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #2;
      w0 = wr_cnt;
      req(13, 14, 0, 0, 0, 0, 0, 0, 16, acc);
      check("fifth stalls", {31'b0, acc}, 32'd0);
      check("no write when full", 32'(wr_cnt), 32'(w0));
      pulse_clear();
      @(negedge clk);
      check("full cleared", {31'b0, full}, 32'd0);
      @(posedge clk);
      #2;
      send_chk("b after clear", 13, 14, 0, 0, 0, 0, 0, 0, 16, 32'hEA000010, 0);

      // illegal requests leave the pointer where it was
      w0 = wr_cnt;
      e0 = err_cnt;
      req(14, 14, 0, 0, 0, 0, 0, 0, 0, acc);
      idle(3);
      req(0, 14, 0, 1, 1, 2, 0, 0, 32'h100, acc);
      idle(3);
      req(6, 14, 0, 0, 15, 1, 2, 0, 0, acc);
      idle(3);
      check("illegal err pulses", 32'(err_cnt), 32'(e0 + 3));
      check("illegal no writes", 32'(wr_cnt), 32'(w0));
      send_chk("add after illegal", 0, 14, 0, 1, 1, 2, 0, 0, 5, 32'hE2821005, 1);

      // reset and clear during the encode cycle abort the write
      w0 = wr_cnt;
      req(0, 14, 0, 1, 1, 2, 0, 0, 5, acc);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(3);
      check("reset in enc no write", 32'(wr_cnt), 32'(w0));
      req(0, 14, 0, 1, 1, 2, 0, 0, 5, acc);
      pulse_clear();
      idle(3);
      check("clear in enc no write", 32'(wr_cnt), 32'(w0));
      set_fields(13, 14, 0, 0, 0, 0, 0, 0, 1);
      req_valid = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      check("clear blocks ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #2;
      req_valid = 1'b0;
      clear = 1'b0;
      idle(3);
      check("clear with valid no write", 32'(wr_cnt), 32'(w0));

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         pick = $urandom_range(0, 3);
         imm  = (pick == 0) ? ($urandom & 32'hFFFFFF) :
                (pick == 1) ? $urandom_range(0, 4095) : $urandom_range(0, 255);
         set_fields($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15), imm);
         req_valid = ($urandom_range(0, 9) < 7);
         clear     = ($urandom_range(0, 99) < 4);
         reset     = ($urandom_range(0, 199) < 1);
         idle(1);
      end
      req_valid = 1'b0;
      clear = 1'b0;
      reset = 1'b0;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
